// File: rtl/dev_reshuffler_pkg.sv
// rtl/dev_reshuffler_pkg.sv - shared types and width helpers for the buffered reshuffler
package dev_reshuffler_pkg;

    typedef enum logic [1:0] {
        MODE_PASS      = 2'b00,
        MODE_TRANSPOSE = 2'b01,
        MODE_ROWREV    = 2'b10
    } mode_e;

    // Occupancy must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointers index 0..depth-1; keep at least one bit so depth=1 still has a vector.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dev_reshuffler_perm.sv
// rtl/dev_reshuffler_perm.sv - combinational tile permutation network
module dev_reshuffler_perm
    import dev_reshuffler_pkg::*;
#(
    parameter int SpatPar = 8,
    parameter int Elems   = 8
) (
    input  logic [SpatPar*SpatPar*Elems-1:0] a_i,
    input  logic [1:0]                       mode_i,
    output logic [SpatPar*SpatPar*Elems-1:0] z_o
);

    // Route every output element from its source element; the reserved mode falls back to passthrough.
    always_comb begin
        z_o = '0;
        for (int i = 0; i < SpatPar; i++) begin
            for (int j = 0; j < SpatPar; j++) begin
                case (mode_i)
                    MODE_TRANSPOSE:
                        z_o[(i*SpatPar+j)*Elems +: Elems] = a_i[(j*SpatPar+i)*Elems +: Elems];
                    MODE_ROWREV:
                        z_o[(i*SpatPar+j)*Elems +: Elems] = a_i[(i*SpatPar+(SpatPar-1-j))*Elems +: Elems];
                    default:
                        z_o[(i*SpatPar+j)*Elems +: Elems] = a_i[(i*SpatPar+j)*Elems +: Elems];
                endcase
            end
        end
    end

endmodule

// File: rtl/dev_reshuffler_buffered.sv
// rtl/dev_reshuffler_buffered.sv - permutes input tiles per beat and buffers them in a small FIFO
module dev_reshuffler_buffered
    import dev_reshuffler_pkg::*;
#(
    parameter int SpatPar   = 8,
    parameter int DataWidth = 64,
    parameter int Depth     = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [SpatPar*DataWidth-1:0]  a_i,
    input  logic                          a_valid_i,
    output logic                          a_ready_o,
    input  logic [1:0]                    csr_mode_i,
    input  logic                          csr_flush_i,
    output logic [SpatPar*DataWidth-1:0]  z_o,
    output logic                          z_valid_o,
    input  logic                          z_ready_i,
    output logic [$clog2(Depth+1)-1:0]    occupancy_o
);

    localparam int Elems = DataWidth / SpatPar;
    localparam int TileW = SpatPar * DataWidth;
    localparam int CntW  = cnt_width(Depth);
    localparam int PtrW  = ptr_width(Depth);

    logic [TileW-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;

    logic [TileW-1:0] w_perm;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    dev_reshuffler_perm #(
        .SpatPar (SpatPar),
        .Elems   (Elems)
    ) u_perm (
        .a_i    (a_i),
        .mode_i (csr_mode_i),
        .z_o    (w_perm)
    );

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Ready depends only on the stored count, so a pop never frees a slot in the same cycle.
    assign w_full      = (r_count == CntW'(Depth));
    assign w_empty     = (r_count == '0);
    assign a_ready_o   = !w_full;
    assign z_valid_o   = !w_empty;
    assign w_push      = a_valid_i && !w_full && !csr_flush_i;
    assign w_pop       = z_valid_o && z_ready_i && !csr_flush_i;
    assign z_o         = w_empty ? '0 : r_mem[r_rd_ptr];
    assign occupancy_o = r_count;

    // Tile storage is deliberately left unreset; validity is tracked by the count alone.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_perm;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over any handshake in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (csr_flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dev_reshuffler_buffered.sv
// tb/tb_dev_reshuffler_buffered.sv - scoreboard bench for the buffered reshuffler
module tb_dev_reshuffler_buffered;

    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [511:0] a_i;
    logic         a_valid_i;
    logic         a_ready_o;
    logic [1:0]   csr_mode_i;
    logic         csr_flush_i;
    logic [511:0] z_o;
    logic         z_valid_o;
    logic         z_ready_i;
    logic [1:0]   occupancy_o;

    int checks   = 0;
    int failures = 0;

    logic [511:0] exp_q [$];

    dev_reshuffler_buffered #(
        .SpatPar   (8),
        .DataWidth (64),
        .Depth     (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .a_i         (a_i),
        .a_valid_i   (a_valid_i),
        .a_ready_o   (a_ready_o),
        .csr_mode_i  (csr_mode_i),
        .csr_flush_i (csr_flush_i),
        .z_o         (z_o),
        .z_valid_o   (z_valid_o),
        .z_ready_i   (z_ready_i),
        .occupancy_o (occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [511:0] ref_perm(input logic [511:0] t, input logic [1:0] m);
        logic [7:0]   e [8][8];
        logic [511:0] r;
        logic [7:0]   v;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                e[i][j] = t[(i*8+j)*8 +: 8];
        r = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (m == 2'b01)      v = e[j][i];
                else if (m == 2'b10) v = e[i][7-j];
                else                 v = e[i][j];
                r[(i*8+j)*8 +: 8] = v;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] elem(input logic [511:0] t, input int i, input int j);
        return t[(i*8+j)*8 +: 8];
    endfunction

    function automatic logic [511:0] pat_tile();
        logic [511:0] t;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                t[(i*8+j)*8 +: 8] = 8'(i*8 + j);
        return t;
    endfunction

    function automatic logic [511:0] rand_tile();
        logic [511:0] t;
        for (int k = 0; k < 16; k++) t[k*32 +: 32] = $urandom;
        return t;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: samples one time unit before each rising edge, compares, then applies that edge's events.
    always begin
        @(negedge clk);
        #4;
        if (rst_i) begin
            chk("mon_rst_ready", 512'(a_ready_o), 512'(1));
            chk("mon_rst_valid", 512'(z_valid_o), 512'(0));
            chk("mon_rst_z", z_o, '0);
            chk("mon_rst_occ", 512'(occupancy_o), 512'(0));
            exp_q.delete();
        end else begin
            chk("mon_occ", 512'(occupancy_o), 512'(exp_q.size()));
            chk("mon_ready", 512'(a_ready_o), 512'(exp_q.size() < DEPTH));
            chk("mon_valid", 512'(z_valid_o), 512'(exp_q.size() > 0));
            if (exp_q.size() > 0) chk("mon_data", z_o, exp_q[0]);
            else                  chk("mon_empty_z", z_o, '0);
            if (csr_flush_i) begin
                exp_q.delete();
            end else begin
                if (z_valid_o && z_ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
                if (a_valid_i && a_ready_o) exp_q.push_back(ref_perm(a_i, csr_mode_i));
            end
        end
    end

    initial begin
        logic [511:0] pat;
        logic [511:0] t0, t1, t2;
        pat         = pat_tile();
        rst_i       = 1'b1;
        a_i         = '0;
        a_valid_i   = 1'b0;
        csr_mode_i  = 2'b00;
        csr_flush_i = 1'b0;
        z_ready_i   = 1'b0;
        #12;
        chk("reset_ready", 512'(a_ready_o), 512'(1));
        chk("reset_valid", 512'(z_valid_o), 512'(0));
        chk("reset_z", z_o, '0);
        chk("reset_occ", 512'(occupancy_o), 512'(0));
        cyc();
        rst_i = 1'b0;

        // Transpose single tile
        a_i = pat; csr_mode_i = 2'b01; a_valid_i = 1'b1; z_ready_i = 1'b1;
        cyc();
        a_valid_i = 1'b0;
        chk("tr_valid", 512'(z_valid_o), 512'(1));
        chk("tr_e10", 512'(elem(z_o, 1, 0)), 512'(8'h01));
        chk("tr_e76", 512'(elem(z_o, 7, 6)), 512'(8'h37));
        cyc();
        chk("tr_drop", 512'(z_valid_o), 512'(0));
        chk("tr_z0", z_o, '0);

        // Row-reverse then passthrough, back-to-back
        a_valid_i = 1'b1; csr_mode_i = 2'b10;
        cyc();
        chk("rr_ready1", 512'(a_ready_o), 512'(1));
        chk("rr_e00", 512'(elem(z_o, 0, 0)), 512'(8'h07));
        chk("rr_e37", 512'(elem(z_o, 3, 7)), 512'(8'h18));
        csr_mode_i = 2'b00;
        cyc();
        a_valid_i = 1'b0;
        chk("rr_ready2", 512'(a_ready_o), 512'(1));
        chk("pass_tile", z_o, pat);
        cyc();
        chk("rr_empty", 512'(z_valid_o), 512'(0));

        // Fill under backpressure, then drain
        t0 = rand_tile(); t1 = rand_tile(); t2 = rand_tile();
        z_ready_i = 1'b0; a_valid_i = 1'b1; a_i = t0;
        cyc();
        a_i = t1;
        cyc();
        a_i = t2;
        chk("full_occ", 512'(occupancy_o), 512'(2));
        chk("full_ready", 512'(a_ready_o), 512'(0));
        cyc();
        chk("full_hold_occ", 512'(occupancy_o), 512'(2));
        chk("full_head", z_o, t0);
        z_ready_i = 1'b1;
        cyc();
        chk("pop_only_occ", 512'(occupancy_o), 512'(1));
        chk("pop_only_ready", 512'(a_ready_o), 512'(1));
        chk("order_t1", z_o, t1);
        cyc();
        a_valid_i = 1'b0;
        chk("third_in_occ", 512'(occupancy_o), 512'(1));
        chk("order_t2", z_o, t2);
        cyc();
        chk("drain_occ", 512'(occupancy_o), 512'(0));

        // Flush beats simultaneous push and pop
        z_ready_i = 1'b0; a_valid_i = 1'b1; a_i = rand_tile();
        cyc();
        a_valid_i = 1'b0;
        chk("pre_flush_occ", 512'(occupancy_o), 512'(1));
        csr_flush_i = 1'b1; a_valid_i = 1'b1; z_ready_i = 1'b1;
        cyc();
        csr_flush_i = 1'b0; a_valid_i = 1'b0;
        chk("flush_occ", 512'(occupancy_o), 512'(0));
        chk("flush_valid", 512'(z_valid_o), 512'(0));
        chk("flush_z", z_o, '0);

        // Random stress with a mid-stream asynchronous reset
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                #2;
                rst_i = 1'b1;
                #1;
                chk("async_rst_occ", 512'(occupancy_o), 512'(0));
                chk("async_rst_valid", 512'(z_valid_o), 512'(0));
                chk("async_rst_ready", 512'(a_ready_o), 512'(1));
                chk("async_rst_z", z_o, '0);
                cyc();
                rst_i = 1'b0;
            end
            a_i         = rand_tile();
            csr_mode_i  = 2'($urandom_range(0, 3));
            if (n >= 190 && n < 200) begin
                a_valid_i   = 1'b1;
                z_ready_i   = 1'b0;
                csr_flush_i = 1'b0;
            end else begin
                a_valid_i   = ($urandom_range(0, 3) != 0);
                z_ready_i   = ($urandom_range(0, 2) != 0);
                csr_flush_i = ($urandom_range(0, 31) == 0);
            end
            cyc();
        end

        a_valid_i = 1'b0; csr_flush_i = 1'b0; z_ready_i = 1'b1;
        repeat (4) cyc();
        chk("final_occ", 512'(occupancy_o), 512'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
